// File: rtl/seg_display_scan_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table and all-off levels.
// Pure constants, no timing or flow control of its own.
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a}, entry n is the glyph for hex digit n
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } idx_t;

endpackage

// File: rtl/seg_display_scan_if.sv
// Display-side bundle: data word in with its load strobe, anode/segment/dp pins out.
// No handshake: load is sampled every cycle, the pins are free-running.
interface seg_display_scan_if;

    logic [15:0] displayIn;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output displayIn, output load, input an, input seg, input dp);
    modport slave  (input displayIn, input load, output an, output seg, output dp);

endinterface

// File: rtl/seg_display_scan_hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
// Zero latency, no flow control.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_display_scan.sv
// Captures a 16-bit word and scans it as four hex digits onto a common-anode display.
// Outputs registered (1 cycle behind idx/shown); load is never back-pressured.
module seg_display_scan
    import display_pkg::*;
#(
    parameter int SCAN_TICKS    = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    seg_display_scan_if.slave  bus
);

    localparam int TICK_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    idx_t              idx_q, idx_d;
    logic [15:0]       pending_q, pending_d;
    logic [15:0]       shown_q, shown_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q;
    logic              tick_wrap, boundary, blank;
    logic [3:0]        nibble;
    logic [6:0]        glyph;

    hex_to_seg u_hex_to_seg (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    assign tick_wrap = (tick_q == TICK_LAST);
    assign boundary  = tick_wrap && (idx_q == DIG3);
    assign nibble    = shown_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
        idx_d     = idx_q;
        pending_d = bus.load ? bus.displayIn : pending_q;
        // A load on the boundary edge is forwarded so it lands in this frame
        shown_d   = boundary ? pending_d : shown_q;
        if (tick_wrap) begin
            case (idx_q)
                DIG0:    idx_d = DIG1;
                DIG1:    idx_d = DIG2;
                DIG2:    idx_d = DIG3;
                default: idx_d = DIG0;
            endcase
        end
    end

    always_comb begin
        blank = 1'b0;
        if (BLANK_LEADING != 0) begin
            case (idx_q)
                DIG1:    blank = (shown_q[15:4]  == '0);
                DIG2:    blank = (shown_q[15:8]  == '0);
                DIG3:    blank = (shown_q[15:12] == '0);
                default: blank = 1'b0;
            endcase
        end
        case (idx_q)
            DIG0:    an_d = 4'b1110;
            DIG1:    an_d = 4'b1101;
            DIG2:    an_d = 4'b1011;
            default: an_d = 4'b0111;
        endcase
        seg_d = glyph;
        if (blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_q    <= '0;
            idx_q     <= DIG0;
            pending_q <= '0;
            shown_q   <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shown_q   <= shown_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= 1'b1;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with SCAN_TICKS=4 and leading-zero blanking.
module tb_seg_display_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    seg_display_scan_if bus ();

    seg_display_scan #(.SCAN_TICKS(4), .BLANK_LEADING(1)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic check(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        logic [11:0] obs, exp;
        obs = {bus.an, bus.seg, bus.dp};
        exp = {an_e, seg_e, 1'b1};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d an/seg/dp=%b_%b_%b expected=%b_%b_1",
                   tag, cyc, bus.an, bus.seg, bus.dp, an_e, seg_e);
        end
    endtask

    task automatic load_word(input logic [15:0] w);
        bus.displayIn = w;
        bus.load      = 1'b1;
        step();
        bus.load      = 1'b0;
    endtask

    initial begin
        bus.displayIn = 16'h0;
        bus.load      = 1'b0;

        // Reset hold
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_hold", 4'b1111, 7'h7F);
        end
        rst_n = 1'b1;
        cyc   = 0;
        check("first_cycle_off", 4'b1111, 7'h7F);
        step();
        check("dig0_zero", 4'b1110, 7'h40);
        goto_cyc(4);
        check("dig0_held", 4'b1110, 7'h40);
        goto_cyc(5);
        check("dig1_blank", 4'b1111, 7'h7F);
        goto_cyc(13);
        check("dig3_blank", 4'b1111, 7'h7F);

        // Full word, loaded mid-frame and taken at boundary E16
        goto_cyc(2);
        load_word(16'h13B0);
        goto_cyc(15);
        check("pre_boundary_old", 4'b1111, 7'h7F);
        goto_cyc(17);
        check("full_d0", 4'b1110, 7'h40);
        goto_cyc(21);
        check("full_d1", 4'b1101, 7'h03);
        goto_cyc(25);
        check("full_d2", 4'b1011, 7'h30);
        goto_cyc(29);
        check("full_d3", 4'b0111, 7'h79);

        // Leading blank
        goto_cyc(30);
        load_word(16'h0008);
        goto_cyc(33);
        check("lb_d0", 4'b1110, 7'h00);
        goto_cyc(37);
        check("lb_d1", 4'b1111, 7'h7F);
        goto_cyc(41);
        check("lb_d2", 4'b1111, 7'h7F);
        goto_cyc(45);
        check("lb_d3", 4'b1111, 7'h7F);

        // No tearing: two loads in one frame, last wins at boundary E64
        goto_cyc(50);
        load_word(16'hAAAA);
        goto_cyc(53);
        load_word(16'h5555);
        goto_cyc(55);
        check("nt_old_d1", 4'b1111, 7'h7F);
        goto_cyc(61);
        check("nt_old_d3", 4'b1111, 7'h7F);
        goto_cyc(65);
        check("nt_d0", 4'b1110, 7'h12);
        goto_cyc(69);
        check("nt_d1", 4'b1101, 7'h12);
        goto_cyc(73);
        check("nt_d2", 4'b1011, 7'h12);
        goto_cyc(77);
        check("nt_d3", 4'b0111, 7'h12);

        // Boundary load: pulse captured on boundary edge E80
        goto_cyc(79);
        load_word(16'hF00F);
        check("bl_d3_prev", 4'b0111, 7'h12);
        goto_cyc(81);
        check("bl_d0", 4'b1110, 7'h0E);
        goto_cyc(85);
        check("bl_d1", 4'b1101, 7'h40);
        goto_cyc(89);
        check("bl_d2", 4'b1011, 7'h40);

        // Reset mid-frame while digit 2 is lit
        goto_cyc(90);
        check("mid_d2_lit", 4'b1011, 7'h40);
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b1111, 7'h7F);
        step();
        check("reset_held", 4'b1111, 7'h7F);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        check("restart_d0", 4'b1110, 7'h40);
        goto_cyc(5);
        check("restart_d1_blank", 4'b1111, 7'h7F);
        goto_cyc(17);
        check("restart_frame2_d0", 4'b1110, 7'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
